// File: rtl/ie_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ie_operand_stage_pkg
//  Purpose  : Shared widths, ALU opcode encoding, EX control bundle and the
//             bubble control value for the ID/EX operand stage.
//  Contents : XLEN, RIDX, alu_op_e (ALU_ADD..ALU_SRL), ex_ctrl_t,
//             BUBBLE_CTRL, fwd_hit() helper.
//  Revision : 1.0  initial release
// ============================================================================
package ie_operand_stage_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    // Control that travels with an instruction into EX.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_ctrl;
    } ex_ctrl_t;

    // A bubble does nothing: no writes, no memory access, ALU opcode ADD.
    localparam ex_ctrl_t BUBBLE_CTRL = '{
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        alu_ctrl:  3'(ALU_ADD)
    };

    // A later stage supplies the operand when it writes the same, non-x0
    // register. x0 never forwards so it always reads its stored value.
    function automatic logic fwd_hit(input logic            we,
                                     input logic [RIDX-1:0] rd,
                                     input logic [RIDX-1:0] rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ie_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ie_fwd_mux
//  Purpose  : Forwarding selector for one EX source operand. MEM result wins
//             over WB result; otherwise the stored register-file data is used.
//  Ports    : rs/rs_data        stored source index and data
//             mem_we/rd/data    MEM stage writeback
//             wb_we/rd/data     WB stage writeback
//             fwd_data          forwarded operand
//  Revision : 1.0  initial release
// ============================================================================
module ie_fwd_mux
    import ie_operand_stage_pkg::*;
(
    input  logic [RIDX-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic            mem_we,
    input  logic [RIDX-1:0] mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = fwd_hit(mem_we, mem_rd, rs);
    assign w_wb_hit  = fwd_hit(wb_we,  wb_rd,  rs);

    always_comb begin
        fwd_data = rs_data;
        if (w_mem_hit) begin
            fwd_data = mem_data;
        end else if (w_wb_hit) begin
            fwd_data = wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ie_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ie_operand_stage
//  Purpose  : ID/EX pipeline register plus operand select. Captures decode
//             fields, forwards MEM/WB results onto the stored sources, picks
//             register or immediate for SrcB and reports load-use hazards.
//  Config   : IE_FORWARDING_EN - when defined, MEM/WB forwarding and stall
//             refresh are active and the hazard covers loads only. When
//             undefined, operands come straight from stored register data and
//             the hazard covers every RAW on the EX destination.
//  Ports    : clk, rst_n (async, active low)
//             id_*              decode-slot instruction fields
//             stall, flush      hold / bubble requests (flush wins)
//             mem_*, wb_*       later-stage writebacks for forwarding
//             ex_valid, src_a, src_b, alu_control, ex_store_data,
//             ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
//             load_use_hazard   combinational stall request
//  Revision : 1.0  initial release
// ============================================================================
module ie_operand_stage
    import ie_operand_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RIDX-1:0] id_rs1,
    input  logic [RIDX-1:0] id_rs2,
    input  logic [RIDX-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [2:0]      id_alu_ctrl,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_we,
    input  logic            wb_we,
    input  logic [RIDX-1:0] mem_rd,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    output logic [XLEN-1:0] src_a,
    output logic [XLEN-1:0] src_b,
    output logic [2:0]      alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RIDX-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_hazard
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [RIDX-1:0] r_rs1;
    logic [RIDX-1:0] r_rs2;
    logic [RIDX-1:0] r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_alu_src;
    ex_ctrl_t        r_ctrl;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    ex_ctrl_t        w_id_ctrl;
    logic            w_haz_kind;

    // Invalid decode slots enter EX with bubble control.
    always_comb begin
        w_id_ctrl = BUBBLE_CTRL;
        if (id_valid) begin
            w_id_ctrl.reg_write = id_reg_write;
            w_id_ctrl.mem_read  = id_mem_read;
            w_id_ctrl.mem_write = id_mem_write;
            w_id_ctrl.alu_ctrl  = id_alu_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_src  <= 1'b0;
            r_ctrl     <= BUBBLE_CTRL;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_src  <= 1'b0;
            r_ctrl     <= BUBBLE_CTRL;
        end else if (stall) begin
            // Absorb any writeback seen this cycle; once that stage retires
            // its value would otherwise be gone before EX resumes.
            r_rs1_data <= w_fwd_a;
            r_rs2_data <= w_fwd_b;
        end else begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_alu_src  <= id_alu_src;
            r_ctrl     <= w_id_ctrl;
        end
    end

`ifdef IE_FORWARDING_EN
    ie_fwd_mux u_fwd_a (
        .rs       (r_rs1),
        .rs_data  (r_rs1_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_a)
    );

    ie_fwd_mux u_fwd_b (
        .rs       (r_rs2),
        .rs_data  (r_rs2_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .fwd_data (w_fwd_b)
    );

    // Only a load leaves its result too late to forward into EX.
    assign w_haz_kind = r_ctrl.mem_read;
`else
    assign w_fwd_a = r_rs1_data;
    assign w_fwd_b = r_rs2_data;

    // Without forwarding every pending register write is a hazard.
    assign w_haz_kind = r_ctrl.reg_write;

    // Later-stage ports and stored indices have no consumer in this build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{mem_we, wb_we, mem_rd, wb_rd, mem_data, wb_data,
                            r_rs1, r_rs2};
`endif

    assign load_use_hazard = r_valid && w_haz_kind && (r_rd != '0) &&
                             ((r_rd == id_rs1) || (r_rd == id_rs2)) && id_valid;

    assign ex_valid      = r_valid;
    assign src_a         = w_fwd_a;
    assign src_b         = r_alu_src ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign alu_control   = r_ctrl.alu_ctrl;
    assign ex_pc         = r_pc;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;

endmodule
`default_nettype wire

// File: tb/tb_ie_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ie_operand_stage
//  Purpose  : Scoreboard bench for ie_operand_stage. Stimulus pushes the
//             expected EX outputs from a behavioural model; a monitor pops
//             and compares once per cycle. Directed cases plus random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ie_operand_stage;

`ifdef IE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        id_valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  op;
        logic        src, rw, mr, mw;
        logic        stall, flush;
        logic        mem_we, wb_we;
        logic [4:0]  mem_rd, wb_rd;
        logic [31:0] mem_data, wb_data;
    } stim_t;

    // Architectural content of the EX slot.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [2:0]  op;
        logic        src, rw, mr, mw;
    } ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] a, b, store;
        logic [2:0]  alu;
        logic        rw, mr, mw, haz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush, mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic        ex_valid;
    logic [31:0] src_a, src_b, ex_store_data, ex_pc;
    logic [2:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;

    int   n_checks = 0;
    int   n_fail   = 0;
    ex_t  m;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ie_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .mem_we(mem_we), .wb_we(wb_we), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_data(mem_data), .wb_data(wb_data),
        .ex_valid(ex_valid), .src_a(src_a), .src_b(src_b),
        .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .load_use_hazard(load_use_hazard)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_fwd(input logic [4:0] idx,
                                          input logic [31:0] stored,
                                          input stim_t s);
        logic [31:0] v;
        v = stored;
`ifdef IE_FORWARDING_EN
        if (idx != 5'd0 && s.mem_we && s.mem_rd == idx)     v = s.mem_data;
        else if (idx != 5'd0 && s.wb_we && s.wb_rd == idx)  v = s.wb_data;
`endif
        return v;
    endfunction

    function automatic logic m_haz(input ex_t x, input stim_t s);
        logic kind;
        kind = FWD ? x.mr : x.rw;
        return x.valid && kind && x.rd != 5'd0 &&
               (x.rd == s.rs1 || x.rd == s.rs2) && s.id_valid;
    endfunction

    function automatic ex_t m_next(input ex_t x, input stim_t s);
        ex_t n;
        n = x;
        if (s.flush) begin
            n = '0;
        end else if (s.stall) begin
            n.d1 = m_fwd(x.rs1, x.d1, s);
            n.d2 = m_fwd(x.rs2, x.d2, s);
        end else begin
            n.valid = s.id_valid;
            n.pc = s.pc; n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd;
            n.d1 = s.d1; n.d2 = s.d2; n.imm = s.imm; n.src = s.src;
            n.op = s.id_valid ? s.op : 3'd0;
            n.rw = s.id_valid & s.rw;
            n.mr = s.id_valid & s.mr;
            n.mw = s.id_valid & s.mw;
        end
        return n;
    endfunction

    // ---------------- driver ----------------
    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s = '0;
        s.id_valid = ($urandom_range(0, 3) != 0);
        s.pc       = $urandom();
        s.rs1      = 5'($urandom_range(0, 7));
        s.rs2      = 5'($urandom_range(0, 7));
        s.rd       = 5'($urandom_range(0, 7));
        s.d1       = $urandom();
        s.d2       = $urandom();
        s.imm      = $urandom();
        s.op       = 3'($urandom_range(0, 7));
        s.src      = 1'($urandom_range(0, 1));
        s.rw       = 1'($urandom_range(0, 1));
        s.mr       = 1'($urandom_range(0, 1));
        s.mw       = 1'($urandom_range(0, 1));
        s.stall    = ($urandom_range(0, 3) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.mem_we   = 1'($urandom_range(0, 1));
        s.wb_we    = 1'($urandom_range(0, 1));
        s.mem_rd   = 5'($urandom_range(0, 7));
        s.wb_rd    = 5'($urandom_range(0, 7));
        s.mem_data = $urandom();
        s.wb_data  = $urandom();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.id_valid; id_pc = s.pc;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
        id_alu_ctrl = s.op; id_alu_src = s.src;
        id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw;
        stall = s.stall; flush = s.flush;
        mem_we = s.mem_we; wb_we = s.wb_we; mem_rd = s.mem_rd; wb_rd = s.wb_rd;
        mem_data = s.mem_data; wb_data = s.wb_data;
    endtask

    // Called at a falling edge: drive inputs and queue what EX should show.
    task automatic drive(input stim_t s);
        exp_t e;
        apply(s);
        e.valid = m.valid;
        e.pc    = m.pc;
        e.rd    = m.rd;
        e.a     = m_fwd(m.rs1, m.d1, s);
        e.store = m_fwd(m.rs2, m.d2, s);
        e.b     = m.src ? m.imm : e.store;
        e.alu   = m.op;
        e.rw    = m.rw;
        e.mr    = m.mr;
        e.mw    = m.mw;
        e.haz   = m_haz(m, s);
        exp_q.push_back(e);
    endtask

    task automatic clock(input stim_t s);
        @(posedge clk);
        m = m_next(m, s);
        @(negedge clk);
    endtask

    task automatic cycle(input stim_t s);
        drive(s);
        clock(s);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
        chk({tag, "_src_a"}, src_a, 32'd0);
        chk({tag, "_src_b"}, src_b, 32'd0);
        chk({tag, "_alu"},   32'(alu_control), 32'd0);
        chk({tag, "_ctrl"},  32'({ex_reg_write, ex_mem_read, ex_mem_write}), 32'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_valid", 32'(ex_valid), 32'(e.valid));
                chk("sb_pc",    ex_pc, e.pc);
                chk("sb_rd",    32'(ex_rd), 32'(e.rd));
                chk("sb_src_a", src_a, e.a);
                chk("sb_src_b", src_b, e.b);
                chk("sb_store", ex_store_data, e.store);
                chk("sb_alu",   32'(alu_control), 32'(e.alu));
                chk("sb_ctrl",  32'({ex_reg_write, ex_mem_read, ex_mem_write}),
                                32'({e.rw, e.mr, e.mw}));
                chk("sb_haz",   32'(load_use_hazard), 32'(e.haz));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        m = '0;
        rst_n = 1'b0;
        apply(rand_stim());
        @(negedge clk);
        #1 chk_reset("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain load
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd9; s.d1 = 32'd5;
        s.imm = 32'd7; s.src = 1'b1; s.op = 3'b000;
        cycle(s);
        s = idle();
        drive(s);
        #3;
        chk("load_src_a", src_a, 32'd5);
        chk("load_src_b", src_b, 32'd7);
        chk("load_alu",   32'(alu_control), 32'd0);
        chk("load_valid", 32'(ex_valid), 32'd1);
        clock(s);

        // Forward priority on x3, EX held by stall
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd3; s.d1 = 32'd1; s.rd = 5'd7;
        cycle(s);
        s = idle(); s.stall = 1'b1;
        s.mem_we = 1'b1; s.mem_rd = 5'd3; s.mem_data = 32'hAA;
        s.wb_we  = 1'b1; s.wb_rd  = 5'd3; s.wb_data  = 32'hBB;
        drive(s);
        #3 chk("fwd_mem_over_wb", src_a, FWD ? 32'hAA : 32'd1);
        clock(s);
        s.mem_we = 1'b0;
        drive(s);
        #3 chk("fwd_wb_only", src_a, FWD ? 32'hBB : 32'd1);
        clock(s);
        s = idle(); s.id_valid = 1'b1;
        cycle(s);
        s = idle();
        s.mem_we = 1'b1; s.mem_data = 32'hAA;
        s.wb_we  = 1'b1; s.wb_data  = 32'hBB;
        drive(s);
        #3 chk("fwd_x0", src_a, 32'd0);
        clock(s);

        // Stall refresh of rs2 = x4
        s = idle(); s.id_valid = 1'b1; s.rs2 = 5'd4; s.d2 = 32'h11;
        cycle(s);
        s = idle(); s.stall = 1'b1;
        s.wb_we = 1'b1; s.wb_rd = 5'd4; s.wb_data = 32'h55;
        drive(s);
        #3 chk("stall_wb_cycle", src_b, FWD ? 32'h55 : 32'h11);
        clock(s);
        s.wb_we = 1'b0; s.wb_data = 32'h0;
        drive(s);
        #3 chk("stall_refresh", src_b, FWD ? 32'h55 : 32'h11);
        clock(s);

        // Flush together with stall
        s = idle(); s.id_valid = 1'b1; s.rw = 1'b1; s.mw = 1'b1; s.rd = 5'd2;
        cycle(s);
        s = idle(); s.stall = 1'b1; s.flush = 1'b1;
        cycle(s);
        s = idle();
        drive(s);
        #3;
        chk("flush_valid", 32'(ex_valid), 32'd0);
        chk("flush_rw",    32'(ex_reg_write), 32'd0);
        chk("flush_mw",    32'(ex_mem_write), 32'd0);
        clock(s);

        // Load-use: lw x5 in EX, add x6,x5,x1 in decode
        s = idle(); s.id_valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd5;
        cycle(s);
        s = idle(); s.id_valid = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd1;
        s.rd = 5'd6; s.rw = 1'b1;
        drive(s);
        #3 chk("lu_hazard", 32'(load_use_hazard), 32'd1);
        clock(s);
        // add x6 now in EX; consumer of x6 is a hazard only without forwarding
        s = idle(); s.id_valid = 1'b1; s.rs2 = 5'd6;
        drive(s);
        #3 chk("raw_alu", 32'(load_use_hazard), FWD ? 32'd0 : 32'd1);
        clock(s);
        s = idle(); s.id_valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd0;
        cycle(s);
        s = idle(); s.id_valid = 1'b1;
        drive(s);
        #3 chk("lu_x0", 32'(load_use_hazard), 32'd0);
        clock(s);

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                s = rand_stim(); s.flush = 1'b0; s.stall = 1'b0;
                s.id_valid = 1'b1; s.rw = 1'b1;
                cycle(s);
                #3 rst_n = 1'b0;
                #1 chk_reset("reset_mid");
                m = '0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle(rand_stim());
        end

        @(negedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ie_operand_stage.md
# ie_operand_stage

ID/EX pipeline register and operand-select stage feeding the execute ALU. Captures decoded operands and control from decode, applies EX-stage forwarding from MEM and WB, selects register or immediate for the second operand, and presents SrcA/SrcB/ALUControl to the ALU one cycle after decode. Also handles stall/flush bubbles and reports load-use hazards back to the hazard unit.

## Interface
- XLEN, 32, datapath width
- RIDX, 5, register index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  RIDX  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_ctrl  in  3  ALU opcode (000 ADD … 111 SRL)
- id_alu_src  in  1  0: SrcB = rs2, 1: SrcB = imm
- id_reg_write, id_mem_read, id_mem_write  in  1  downstream control
- stall  in  1  hold EX contents
- flush  in  1  insert bubble into EX
- mem_we, wb_we  in  1  MEM/WB stage will write rd
- mem_rd, wb_rd  in  RIDX  MEM/WB destination
- mem_data, wb_data  in  XLEN  MEM/WB result
- ex_valid  out  1  EX slot valid
- src_a, src_b  out  XLEN  ALU operands (post-forward, post-mux)
- alu_control  out  3  ALU opcode
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_pc  out  XLEN, ex_rd  out  RIDX
- ex_reg_write, ex_mem_read, ex_mem_write  out  1
- load_use_hazard  out  1  combinational stall request to hazard unit

## Operation
- Register update priority per edge: flush > stall > load.
- Load: all id_* fields captured; ex_valid <= id_valid; if !id_valid, control bits captured as 0.
- Flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, alu_control <= 0; data fields don't-care but cleared to 0.
- Stall: all fields hold, except stored rs1/rs2 data refreshed with forwarded value each cycle so a WB write that retires during the stall is not lost.
- Forwarding (per source, combinational from stored index): MEM match if mem_we && mem_rd==rs && rs!=0; else WB match under same rule; else stored data. MEM wins over WB. x0 always reads stored value (0).
- src_a = fwd(rs1); src_b = id_alu_src-registered ? imm : fwd(rs2); ex_store_data = fwd(rs2) regardless of alu_src.
- load_use_hazard = ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2) && id_valid.
- All arithmetic is XLEN-bit; no width extension here.

## Timing
- Latency: 1 cycle from id_* to src_a/src_b/alu_control.
- Forwarding path is combinational within the EX cycle; no extra latency.
- Reset (async, rst_n low): every registered output and ex_valid = 0, so src_a = src_b = 0, alu_control = 000; release is synchronous to next clk edge.
- Reset mid-stall or mid-flush: reset dominates, state cleared immediately.
- stall and flush together: flush wins, bubble inserted.
- load_use_hazard asserted in same cycle as the dependent instruction in decode; hazard unit asserts stall upstream and flush here next edge.

## Configuration
- IE_FORWARDING_EN defined: MEM/WB forwarding and stall refresh as above.
- Undefined: src_a/src_b/ex_store_data come straight from stored register data; mem_*/wb_* inputs ignored; load_use_hazard widens to any ex_valid && ex_reg_write && ex_rd match (software/hazard unit must stall all RAW cases).

## Structure
- Shared package/header: XLEN, RIDX, ALU opcode constants (ALU_ADD…ALU_SRL), bubble control constant.
- One sub-module: ie_fwd_mux (one per source, instantiated twice), takes stored index/data plus MEM/WB ports, returns forwarded value.

## Test plan
- Reset: rst_n low mid-operation -> all outputs 0, ex_valid 0 immediately.
- Plain load: id_rs1_data=5, id_imm=7, alu_src=1, alu_ctrl=000 -> next cycle src_a=5, src_b=7, alu_control=000.
- Forward priority: stored rs1=x3 data 1, mem_rd=3 data 0xAA, wb_rd=3 data 0xBB -> src_a=0xAA; drop mem_we -> 0xBB; rs1=x0 with both matching -> 0.
- Stall refresh: stall 2 cycles, wb writes x4=0x55 in first stall cycle only, rs2=x4 -> src_b stays 0x55 after WB retires.
- Flush with stall: both high -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Load-use: EX lw x5, decode add x6,x5,x1 -> load_use_hazard=1; rd=x0 -> 0.
